ps2_key_decoder: RTL
====================

# ps2_key_decoder

Consumes the byte stream of a PS/2 keyboard receiver (one scan-code byte per strobe, set 2), interprets E0 (extended) and F0 (break) prefixes, tracks shift state, and converts key presses to ASCII. Characters are queued in a small FIFO and presented on a ready/valid interface to the text/command logic. The block sits directly downstream of the PS/2 byte receiver and runs entirely in the system clock domain.

## Interface
- FIFO_DEPTH, 4, character FIFO entries; power of two, at least 2.
- clock  in  1  system clock, all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- scan_code  in  8  received scan-code byte, valid only while scan_valid is high.
- scan_valid  in  1  one-cycle strobe per received byte, synchronous to clock; may be high on consecutive cycles.
- key_ascii  out  8  ASCII code at FIFO head; 0x00 when FIFO is empty.
- key_valid  out  1  FIFO non-empty.
- key_ready  in  1  consumer accepts head; a pop occurs on key_valid && key_ready.
- shift_held  out  1  left or right shift currently pressed.
- overflow  out  1  sticky; set when a character is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of queued characters.

## Operation
- Prefix FSM, states IDLE, GOT_E0, GOT_F0, GOT_E0F0; advances only on scan_valid.
- Any state, byte 0x00 or 0xFF (keyboard error): discard, go IDLE, no other effect.
- IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other -> normal make, stay IDLE.
- GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> stay GOT_E0; other -> extended make, IDLE.
- GOT_F0: any byte -> normal break of that byte, IDLE.
- GOT_E0F0: any byte -> extended break, IDLE.
- Shift: normal make/break of 0x12 sets/clears lshift, 0x59 sets/clears rshift; shift_held = lshift | rshift. Extended 0x12/0x59 ignored.
- Only makes generate characters; breaks only affect shift; repeated makes (typematic) each enqueue a character.
- Normal make translation, using shift state before this byte is applied:
  - letters, lowercase unshifted, uppercase shifted: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A.
  - digits 1..9,0 = 16 1E 26 25 2E 36 3D 3E 46 45; shifted give ! @ # $ % ^ & * ( ).
  - 0x29 -> 0x20, 0x5A -> 0x0D, 0x66 -> 0x08, regardless of shift.
- Extended make: only E0 5A (keypad enter) -> 0x0D; all others produce nothing.
- Unmapped codes (incl. 0xAA, 0xFA) produce nothing and do not alter the FSM beyond the rules above.
- FIFO: push translated character; pop on handshake; full and push without pop -> drop new char, set overflow; full with simultaneous push and pop -> both succeed, no overflow; empty with push and key_ready -> no pop that cycle.

## Timing
- Reset (resetn low, asynchronous): FSM IDLE, lshift=rshift=0, FIFO empty, key_valid=0, key_ascii=0x00, shift_held=0, overflow=0, fifo_count=0.
- Deassertion of resetn is used synchronously; first byte accepted on the first rising edge with resetn high.
- Latency: make byte sampled at edge N -> character at head with key_valid=1 after edge N (one clock) if FIFO was empty.
- shift_held updates after the edge that samples the 0x12/0x59 make or break byte.
- Pop at edge M: key_ascii shows next entry (or 0x00) after edge M.
- Back-to-back scan_valid: every byte processed, no bytes lost other than by FIFO overflow.
- key_ascii/key_valid are stable while key_valid && !key_ready.

## Test plan
- Bytes 0x1C, F0 1C with key_ready=1 -> one char 0x61, key_valid for one cycle, one clock after first byte; no char for the break.
- Bytes 12, 1C, F0 12, 1C -> chars 0x41 then 0x61; shift_held 1 between make and break of 0x12.
- Bytes E0 5A, E0 F0 5A, E0 12, 16 -> chars 0x0D then 0x31; shift_held stays 0.
- key_ready=0, make 0x15,0x1D,0x24,0x2D,0x2C -> fifo_count=4, overflow=1, pops yield 0x71 0x77 0x65 0x72.
- FIFO full, make 0x29 same cycle as pop -> fifo_count stays 4, overflow stays 0, tail 0x20.
- Bytes F0 then resetn low mid-stream, then 0x1C -> no break effect, char 0x61, all outputs zero during reset.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: tracks E0/F0 prefixes and shift state,
// translates key makes to ASCII and queues them on a ready/valid FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [7:0]                    scan_code,
  input  logic                          scan_valid,
  output logic [7:0]                    key_ascii,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          shift_held,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t state, next_state;
  logic   lshift, rshift;

  // Returns {hit, ascii} for a normal (non-extended) make code.
  function automatic logic [8:0] translate(input logic [7:0] code, input logic shift);
    logic [7:0] base;
    logic [7:0] alt;
    logic       hit;
    logic       letter;
    base   = 8'h00;
    alt    = 8'h00;
    hit    = 1'b1;
    letter = 1'b0;
    case (code)
      8'h1C: begin base = 8'h61; letter = 1'b1; end
      8'h32: begin base = 8'h62; letter = 1'b1; end
      8'h21: begin base = 8'h63; letter = 1'b1; end
      8'h23: begin base = 8'h64; letter = 1'b1; end
      8'h24: begin base = 8'h65; letter = 1'b1; end
      8'h2B: begin base = 8'h66; letter = 1'b1; end
      8'h34: begin base = 8'h67; letter = 1'b1; end
      8'h33: begin base = 8'h68; letter = 1'b1; end
      8'h43: begin base = 8'h69; letter = 1'b1; end
      8'h3B: begin base = 8'h6A; letter = 1'b1; end
      8'h42: begin base = 8'h6B; letter = 1'b1; end
      8'h4B: begin base = 8'h6C; letter = 1'b1; end
      8'h3A: begin base = 8'h6D; letter = 1'b1; end
      8'h31: begin base = 8'h6E; letter = 1'b1; end
      8'h44: begin base = 8'h6F; letter = 1'b1; end
      8'h4D: begin base = 8'h70; letter = 1'b1; end
      8'h15: begin base = 8'h71; letter = 1'b1; end
      8'h2D: begin base = 8'h72; letter = 1'b1; end
      8'h1B: begin base = 8'h73; letter = 1'b1; end
      8'h2C: begin base = 8'h74; letter = 1'b1; end
      8'h3C: begin base = 8'h75; letter = 1'b1; end
      8'h2A: begin base = 8'h76; letter = 1'b1; end
      8'h1D: begin base = 8'h77; letter = 1'b1; end
      8'h22: begin base = 8'h78; letter = 1'b1; end
      8'h35: begin base = 8'h79; letter = 1'b1; end
      8'h1A: begin base = 8'h7A; letter = 1'b1; end
      8'h16: begin base = 8'h31; alt = 8'h21; end
      8'h1E: begin base = 8'h32; alt = 8'h40; end
      8'h26: begin base = 8'h33; alt = 8'h23; end
      8'h25: begin base = 8'h34; alt = 8'h24; end
      8'h2E: begin base = 8'h35; alt = 8'h25; end
      8'h36: begin base = 8'h36; alt = 8'h5E; end
      8'h3D: begin base = 8'h37; alt = 8'h26; end
      8'h3E: begin base = 8'h38; alt = 8'h2A; end
      8'h46: begin base = 8'h39; alt = 8'h28; end
      8'h45: begin base = 8'h30; alt = 8'h29; end
      8'h29: begin base = 8'h20; alt = 8'h20; end
      8'h5A: begin base = 8'h0D; alt = 8'h0D; end
      8'h66: begin base = 8'h08; alt = 8'h08; end
      default: hit = 1'b0;
    endcase
    if (letter) alt = base - 8'h20;
    return {hit, shift ? alt : base};
  endfunction

  logic       make_n, make_e, break_n;
  logic [8:0] tr;
  logic       push;
  logic [7:0] push_data;

  always_comb begin
    next_state = state;
    make_n     = 1'b0;
    make_e     = 1'b0;
    break_n    = 1'b0;
    if (scan_valid) begin
      if (scan_code == 8'h00 || scan_code == 8'hFF) begin
        next_state = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (scan_code == 8'hE0)      next_state = GOT_E0;
            else if (scan_code == 8'hF0) next_state = GOT_F0;
            else                         make_n = 1'b1;
          end
          GOT_E0: begin
            if (scan_code == 8'hF0)      next_state = GOT_E0F0;
            else if (scan_code == 8'hE0) next_state = GOT_E0;
            else begin
              make_e     = 1'b1;
              next_state = IDLE;
            end
          end
          GOT_F0: begin
            break_n    = 1'b1;
            next_state = IDLE;
          end
          default: next_state = IDLE;
        endcase
      end
    end
  end

  // Translation uses the shift state held before this byte takes effect.
  always_comb begin
    tr        = translate(scan_code, shift_held);
    push      = 1'b0;
    push_data = 8'h00;
    if (make_n && tr[8]) begin
      push      = 1'b1;
      push_data = tr[7:0];
    end else if (make_e && scan_code == 8'h5A) begin
      push      = 1'b1;
      push_data = 8'h0D;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      lshift <= 1'b0;
      rshift <= 1'b0;
    end else begin
      state <= next_state;
      if (make_n && scan_code == 8'h12)  lshift <= 1'b1;
      if (break_n && scan_code == 8'h12) lshift <= 1'b0;
      if (make_n && scan_code == 8'h59)  rshift <= 1'b1;
      if (break_n && scan_code == 8'h59) rshift <= 1'b0;
    end
  end

  assign shift_held = lshift | rshift;
  assign fsm_state  = state;

  // Character FIFO; a full FIFO still accepts a push when a pop happens the same cycle.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, push_ok;

  assign pop     = (count != '0) && key_ready;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && full && !pop) overflow <= 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  assign key_valid  = (count != '0);
  assign key_ascii  = key_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

endmodule
